sample_gather8: RTL and testbench
=================================

SAMPLE_GATHER8 -- requirements
Module: sample_gather8

Interface
REQ-001 Parameters: W, 12, sample width in bits (signed two's complement); LANES, 8, samples per bundle (fixed at 8; other values are unsupported).
REQ-002 Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  W  serial signed sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept in_data this cycle.
- n0..n7  out  W each  parallel bundle lanes; n0 carries the first sample received.
- out_valid  out  1  bundle on n0..n7 is valid.
- out_ready  in  1  consumer (adder tree) takes the bundle this cycle.
- sum_valid  out  1  adder-tree sum for a taken bundle is valid (present only with macro, REQ-020).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-004 An input transfer occurs on a rising clk edge where in_valid=1 and in_ready=1; an output transfer occurs where out_valid=1 and out_ready=1.
REQ-005 Fill path: a 3-bit fill index idx (0..7) selects a fill register; each input transfer writes fill[idx] and increments idx, wrapping 7->0.
REQ-006 The output register holds n0..n7 and is loaded with all 8 fill registers in the same edge as the input transfer that writes idx=7 (with the 8th sample written into n7 directly).
REQ-007 FSM states: FILL (idx<7, or output register free) and STALL (idx=7 pending, output register occupied and not being taken).
REQ-008 in_ready = 1 in FILL; in STALL in_ready = out_ready (pass-through, so loading the 8th sample coincides with the old bundle leaving).
REQ-009 out_valid is set on the load edge, cleared on an output transfer with no simultaneous load, and stays 1 on a simultaneous load and take (back-to-back bundles).
REQ-010 While out_valid=1 and out_ready=0, n0..n7 and out_valid shall hold constant.
REQ-011 Latency: the last sample of a bundle, accepted at edge k, appears on n0..n7 with out_valid=1 after edge k (1 cycle).
REQ-012 Throughput: with out_ready held at 1, one bundle per 8 cycles and no in_ready deassertion.
REQ-013 Samples pass bit-exact; there is no arithmetic, sign change or reordering.
REQ-014 in_valid=0 cycles do not advance idx; partial bundles persist indefinitely.

Reset
REQ-015 While rst_n=0: idx=0, state=FILL, out_valid=0, n0..n7=0, fill registers=0, sum_valid=0 (valid pipeline all 0).
REQ-016 Reset asserted mid-bundle discards the partial bundle and any untaken output bundle; the first post-reset sample lands in n0.
REQ-017 After reset release, in_ready=1 on the first cycle.

Configuration
REQ-018 The macro SAMPLE_GATHER_SUMVLD_EN controls the valid-tracking feature.
REQ-019 Defined: a 5-stage valid shift register is loaded with 1 on each output transfer, and sum_valid is its last stage, so sum_valid=1 exactly 5 edges after the output transfer edge. This is the adder tree's pipeline depth.
REQ-020 Not defined: the sum_valid port and the shift register are absent, and all other behaviour is identical.

Structure
REQ-021 Shared package: W default, LANES, adder latency constant (5), and the FSM state enum {FILL, STALL}.
REQ-022 One sub-module, valid_delay_line (depth parameter), holds the REQ-019 shift register; it is instantiated only under the macro.

Verification
REQ-023 Feed samples 1..8 continuously with out_ready=1 -> one cycle after the 8th, n0..n7=1..8, out_valid=1 for 1 cycle, and in_ready never drops.
REQ-024 Feed 16 samples (-2048, 2047, -1, 0, repeating) with out_ready=0 -> the first bundle holds; after the 16th sample is offered, in_ready=0; raising out_ready -> the second bundle loads in the same edge and out_valid stays 1.
REQ-025 Feed 5 samples, pulse rst_n low for 1 cycle, then feed 8 samples 100..107 -> the bundle is n0=100..n7=107 and no stale data appears.
REQ-026 Toggle in_valid 1/0 every cycle for 8 samples -> the bundle completes after 15 cycles and the order is preserved.
REQ-027 With the macro defined, output transfers at edges 10 and 18 -> sum_valid=1 exactly at edges 15 and 23, and 0 elsewhere. Without the macro, the compile succeeds with no sum_valid port.

Source files
------------

// File: rtl/sample_gather8_pkg.sv
// ---------------------------------------------------------------------------
// sample_gather8_pkg
//   Shared definitions for the serial-to-parallel sample gatherer:
//     SG_W_DEFAULT : default sample width (signed two's complement)
//     SG_LANES     : samples per bundle (fixed at 8)
//     SG_IDX_W     : width of the fill index
//     SG_ADD_LAT   : pipeline depth of the downstream adder tree
//     sg_state_e   : gatherer FSM states {FILL, STALL}
// ---------------------------------------------------------------------------
package sample_gather8_pkg;

  localparam int unsigned SG_W_DEFAULT = 12;
  localparam int unsigned SG_LANES     = 8;
  localparam int unsigned SG_IDX_W     = 3;
  localparam int unsigned SG_ADD_LAT   = 5;

  // FILL : still collecting, or the output register is free.
  // STALL: last sample pending while an untaken bundle occupies the output.
  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } sg_state_e;

endpackage

// File: rtl/sample_gather8_valid_delay.sv
// ---------------------------------------------------------------------------
// valid_delay_line
//   Fixed-depth shift register of valid bits, tracking bundles through the
//   downstream adder tree.
//   Ports:
//     clk_i   : clock, rising edge
//     rst_ni  : asynchronous active-low reset, clears every stage
//     valid_i : valid bit entering stage 0
//     valid_o : last stage (valid_i delayed by DEPTH edges)
// ---------------------------------------------------------------------------
module valid_delay_line
  import sample_gather8_pkg::*;
#(
  parameter int unsigned DEPTH = SG_ADD_LAT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= valid_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign valid_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sample_gather8.sv
// ---------------------------------------------------------------------------
// sample_gather8
//   Gathers 8 serial signed samples into one parallel bundle for an adder
//   tree. Samples pass bit-exact; n0 carries the first sample of a bundle.
//   Ports:
//     clk        : clock, rising edge
//     rst_n      : asynchronous active-low reset
//     in_data    : serial sample (W bits)
//     in_valid   : in_data valid
//     in_ready   : block accepts in_data this cycle
//     n0..n7     : bundle lanes (W bits each)
//     out_valid  : bundle on n0..n7 valid
//     out_ready  : consumer takes the bundle this cycle
//     sum_valid  : adder-tree result valid (only with SAMPLE_GATHER_SUMVLD_EN)
//   Configuration macro: SAMPLE_GATHER_SUMVLD_EN adds the sum_valid port and
//   a SG_ADD_LAT-deep valid delay line fed by output transfers.
// ---------------------------------------------------------------------------
module sample_gather8
  import sample_gather8_pkg::*;
#(
  parameter int unsigned W = SG_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] n0,
  output logic [W-1:0] n1,
  output logic [W-1:0] n2,
  output logic [W-1:0] n3,
  output logic [W-1:0] n4,
  output logic [W-1:0] n5,
  output logic [W-1:0] n6,
  output logic [W-1:0] n7,
  output logic         out_valid,
  input  logic         out_ready
`ifdef SAMPLE_GATHER_SUMVLD_EN
  ,
  output logic         sum_valid
`endif
);

  localparam logic [SG_IDX_W-1:0] LAST_IDX = SG_IDX_W'(SG_LANES - 1);

  sg_state_e           state_q, state_d;
  logic [SG_IDX_W-1:0] idx_q, idx_d;
  logic                out_valid_q, out_valid_d;

  // Only lanes 0..6 need fill storage: the 8th sample goes straight to n7.
  logic [W-1:0]        fill_q   [SG_LANES-1];
  logic [W-1:0]        bundle_q [SG_LANES];

  logic                in_xfer;
  logic                out_xfer;
  logic                load;

  // In STALL the last sample may only enter while the old bundle leaves.
  always_comb begin
    in_ready = (state_q == STALL) ? out_ready : 1'b1;
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready;
  assign load     = in_xfer & (idx_q == LAST_IDX);

  always_comb begin
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    if (in_xfer) begin
      idx_d = idx_q + SG_IDX_W'(1);
    end
    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    // Registered state anticipates next cycle: last lane pending with the
    // output register still occupied.
    state_d = ((idx_d == LAST_IDX) && out_valid_d) ? STALL : FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < SG_LANES - 1; i++) begin
        fill_q[i] <= '0;
      end
      for (int unsigned i = 0; i < SG_LANES; i++) begin
        bundle_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      if (in_xfer && (idx_q != LAST_IDX)) begin
        fill_q[idx_q] <= in_data;
      end
      if (load) begin
        for (int unsigned i = 0; i < SG_LANES - 1; i++) begin
          bundle_q[i] <= fill_q[i];
        end
        bundle_q[SG_LANES-1] <= in_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign n0 = bundle_q[0];
  assign n1 = bundle_q[1];
  assign n2 = bundle_q[2];
  assign n3 = bundle_q[3];
  assign n4 = bundle_q[4];
  assign n5 = bundle_q[5];
  assign n6 = bundle_q[6];
  assign n7 = bundle_q[7];

`ifdef SAMPLE_GATHER_SUMVLD_EN
  valid_delay_line #(
    .DEPTH(SG_ADD_LAT)
  ) u_sum_vld (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(out_xfer),
    .valid_o(sum_valid)
  );
`endif

endmodule

// File: tb/tb_sample_gather8.sv
module tb_sample_gather8;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] n0, n1, n2, n3, n4, n5, n6, n7;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef SAMPLE_GATHER_SUMVLD_EN
  logic         sum_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sample_gather8 #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .n0       (n0),
    .n1       (n1),
    .n2       (n2),
    .n3       (n3),
    .n4       (n4),
    .n5       (n5),
    .n6       (n6),
    .n7       (n7),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SAMPLE_GATHER_SUMVLD_EN
    ,
    .sum_valid(sum_valid)
`endif
  );

  logic [8*W-1:0] bundle;
  assign bundle = {n7, n6, n5, n4, n3, n2, n1, n0};

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] mk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample, check in_ready before the edge, then take the edge.
  task automatic push(input int d, input logic exp_rdy);
    in_valid = 1'b1;
    in_data  = W'(d);
    #1;
    check("in_ready", 96'(in_ready), 96'(exp_rdy));
    edge1();
    in_valid = 1'b0;
  endtask

`ifdef SAMPLE_GATHER_SUMVLD_EN
  // Expected sum_valid: an output transfer sampled at edge e shows on
  // sum_valid after edge e+4, i.e. it is seen at the 5th edge.
  logic [4:0] take_hist;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) take_hist <= '0;
    else        take_hist <= {take_hist[3:0], out_valid & out_ready};
  end
  always @(negedge clk) begin
    if (rst_n) check("sum_valid", 96'(sum_valid), 96'(take_hist[4]));
  end
`endif

  int pat [4] = '{-2048, 2047, -1, 0};

  initial begin
    // Reset state
    #3;
    check("rst_out_valid", 96'(out_valid), 96'(0));
    check("rst_bundle", 96'(bundle), 96'(0));
    check("rst_in_ready", 96'(in_ready), 96'(1));
    #9 rst_n = 1'b1;
    edge1();
    check("post_rst_in_ready", 96'(in_ready), 96'(1));

    // Continuous 1..8 with out_ready=1
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push(k, 1'b1);
      if (k == 7) check("t1_ov_before", 96'(out_valid), 96'(0));
    end
    check("t1_ov", 96'(out_valid), 96'(1));
    check("t1_bundle", 96'(bundle), mk(1, 2, 3, 4, 5, 6, 7, 8));
    edge1();
    check("t1_ov_drop", 96'(out_valid), 96'(0));

    // Back-pressure: 16 samples with out_ready=0
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      push(pat[i % 4], 1'b1);
      if (i == 7) begin
        check("t2_ov1", 96'(out_valid), 96'(1));
        check("t2_b1", 96'(bundle), mk(-2048, 2047, -1, 0, -2048, 2047, -1, 0));
      end
    end
    check("t2_hold_b", 96'(bundle), mk(-2048, 2047, -1, 0, -2048, 2047, -1, 0));
    in_valid = 1'b1;
    in_data  = W'(pat[3]);
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t2_stall_rdy", 96'(in_ready), 96'(0));
      edge1();
      check("t2_stall_ov", 96'(out_valid), 96'(1));
    end
    out_ready = 1'b1;
    #1;
    check("t2_pass_rdy", 96'(in_ready), 96'(1));
    edge1();
    in_valid = 1'b0;
    check("t2_b2b_ov", 96'(out_valid), 96'(1));
    check("t2_b2", 96'(bundle), mk(-2048, 2047, -1, 0, -2048, 2047, -1, 0));
    edge1();
    check("t2_ov_drop", 96'(out_valid), 96'(0));

    // Reset mid-bundle with an untaken bundle present
    out_ready = 1'b0;
    for (int k = 60; k < 68; k++) push(k, 1'b1);
    check("t3_pending", 96'(out_valid), 96'(1));
    for (int k = 50; k < 55; k++) push(k, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t3_rst_ov", 96'(out_valid), 96'(0));
    check("t3_rst_bundle", 96'(bundle), 96'(0));
    edge1();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 100; k < 108; k++) begin
      push(k, 1'b1);
      if (k == 106) check("t3_ov_before", 96'(out_valid), 96'(0));
    end
    check("t3_ov", 96'(out_valid), 96'(1));
    check("t3_bundle", 96'(bundle), mk(100, 101, 102, 103, 104, 105, 106, 107));
    edge1();

    // in_valid toggling: 8 samples over 15 cycles, idle cycles carry junk
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("t4_ov_before", 96'(out_valid), 96'(0));
      push(-1000 + 37 * k, 1'b1);
      if (k < 7) begin
        in_data = 12'hABC;
        edge1();
      end
    end
    check("t4_ov", 96'(out_valid), 96'(1));
    check("t4_bundle", 96'(bundle), mk(-1000, -963, -926, -889, -852, -815, -778, -741));
    edge1();

    // Partial bundle persists across a long idle gap
    for (int k = 7; k < 10; k++) push(k, 1'b1);
    for (int c = 0; c < 20; c++) begin
      in_data = W'(c + 900);
      edge1();
    end
    check("t5_idle_ov", 96'(out_valid), 96'(0));
    for (int k = 10; k < 15; k++) push(k, 1'b1);
    check("t5_ov", 96'(out_valid), 96'(1));
    check("t5_bundle", 96'(bundle), mk(7, 8, 9, 10, 11, 12, 13, 14));
    repeat (8) edge1();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
